// File: rtl/cacc_slcg_pkg.sv
// Shared types and default widths for the CACC second-level clock-gate controller.
package cacc_slcg_pkg;

   typedef enum logic [1:0] {
      ST_ACTIVE = 2'd0,
      ST_HOLD   = 2'd1,
      ST_GATED  = 2'd2
   } slcgState_e;

   localparam int DEF_HOLD_W      = 8;
   localparam int DEF_PERF_W      = 32;
   localparam int DEF_SYNC_STAGES = 2;

endpackage

// File: rtl/cacc_sync_bit.sv
// Multi-flop synchronizer for a single asynchronous level into the core clock domain.
module cacc_sync_bit
   import cacc_slcg_pkg::*;
#(
   parameter int SYNC_STAGES = DEF_SYNC_STAGES
) (
   input  logic clk_i,
   input  logic rst_i,
   input  logic d_i,
   output logic q_o
);

   logic [SYNC_STAGES-1:0] sync_q;

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         sync_q <= '0;
      end else begin
         sync_q <= {sync_q[SYNC_STAGES-2:0], d_i};
      end
   end

   assign q_o = sync_q[SYNC_STAGES-1];

endmodule

// File: rtl/cacc_slcg_ctrl.sv
// CACC clock-gate enable controller: activity FSM with hold-off, override
// synchronization and a saturating gated-cycle performance counter.
module cacc_slcg_ctrl
   import cacc_slcg_pkg::*;
#(
   parameter int HOLD_W      = DEF_HOLD_W,
   parameter int SYNC_STAGES = DEF_SYNC_STAGES,
   parameter int PERF_W      = DEF_PERF_W
) (
   input  logic              nvdla_core_clk,
   input  logic              nvdla_core_rst,
   input  logic              reg2dp_op_en,
   input  logic [HOLD_W-1:0] cfg_hold_cycles,
   input  logic              accu_busy,
   input  logic              dlv_busy,
   input  logic              csc_req_pend,
   input  logic              dla_clk_ovr_on,
   input  logic              global_clk_ovr_on,
   input  logic              tmc2slcg_disable_clock_gating,
   output logic              slcg_en_src_0,
   output logic              slcg_en_src_1,
   output logic              dla_clk_ovr_on_sync,
   output logic              global_clk_ovr_on_sync,
   output logic              slcg_gated,
   output logic [PERF_W-1:0] dp2reg_gated_cycles
);

   slcgState_e        state_q, state_d;
   logic [HOLD_W-1:0] holdCnt_q, holdCnt_d;
   logic              en0_q, en0_d;
   logic              en1_q, en1_d;
   logic              gated_q;
   logic              opEnDly_q;
   logic [PERF_W-1:0] perf_q, perf_d;
   logic              act;
   logic              ovr;

   cacc_sync_bit #(.SYNC_STAGES(SYNC_STAGES)) uDlaSync (
      .clk_i (nvdla_core_clk),
      .rst_i (nvdla_core_rst),
      .d_i   (dla_clk_ovr_on),
      .q_o   (dla_clk_ovr_on_sync)
   );

   cacc_sync_bit #(.SYNC_STAGES(SYNC_STAGES)) uGlobalSync (
      .clk_i (nvdla_core_clk),
      .rst_i (nvdla_core_rst),
      .d_i   (global_clk_ovr_on),
      .q_o   (global_clk_ovr_on_sync)
   );

   assign act = accu_busy | dlv_busy | csc_req_pend;
   assign ovr = dla_clk_ovr_on_sync | global_clk_ovr_on_sync | tmc2slcg_disable_clock_gating;

   // Activity always wins over hold expiry; override only affects the enables.
   always_comb begin
      state_d   = state_q;
      holdCnt_d = holdCnt_q;
      unique case (state_q)
         ST_ACTIVE: begin
            if (!act) begin
               if (cfg_hold_cycles != '0) begin
                  state_d   = ST_HOLD;
                  holdCnt_d = cfg_hold_cycles - HOLD_W'(1);
               end else begin
                  state_d = ST_GATED;
               end
            end
         end
         ST_HOLD: begin
            if (act) begin
               state_d = ST_ACTIVE;
            end else if (holdCnt_q == '0) begin
               state_d = ST_GATED;
            end else begin
               holdCnt_d = holdCnt_q - HOLD_W'(1);
            end
         end
         ST_GATED: begin
            if (act) begin
               state_d = ST_ACTIVE;
            end
         end
         default: begin
            state_d = ST_HOLD;
         end
      endcase
      en1_d = (state_d != ST_GATED) | ovr;
      en0_d = reg2dp_op_en | ovr | act;
   end

   // A fresh layer enable restarts the count even while gated.
   always_comb begin
      perf_d = perf_q;
      if (reg2dp_op_en && !opEnDly_q) begin
         perf_d = '0;
      end else if (gated_q && (perf_q != '1)) begin
         perf_d = perf_q + PERF_W'(1);
      end
   end

   always_ff @(posedge nvdla_core_clk) begin
      if (nvdla_core_rst) begin
         state_q   <= ST_HOLD;
         holdCnt_q <= '1;
         en0_q     <= 1'b1;
         en1_q     <= 1'b1;
         gated_q   <= 1'b0;
         opEnDly_q <= 1'b0;
         perf_q    <= '0;
      end else begin
         state_q   <= state_d;
         holdCnt_q <= holdCnt_d;
         en0_q     <= en0_d;
         en1_q     <= en1_d;
         gated_q   <= (state_d == ST_GATED);
         opEnDly_q <= reg2dp_op_en;
         perf_q    <= perf_d;
      end
   end

   assign slcg_en_src_0       = en0_q;
   assign slcg_en_src_1       = en1_q;
   assign slcg_gated          = gated_q;
   assign dp2reg_gated_cycles = perf_q;

endmodule

// File: tb/tb_cacc_slcg_ctrl.sv
// Directed bench for cacc_slcg_ctrl: vector table plus multi-cycle corner sequences.
module tb_cacc_slcg_ctrl;

   typedef struct {
      logic       accu;
      logic       dlv;
      logic       csc;
      logic       opEn;
      logic       tmc;
      logic [7:0] cfg;
      logic [2:0] expOut;
   } vec_t;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        opEn = 1'b0;
   logic [7:0]  cfgHold = 8'd0;
   logic        accu = 1'b0;
   logic        dlv = 1'b0;
   logic        csc = 1'b0;
   logic        dlaOvr = 1'b0;
   logic        globalOvr = 1'b0;
   logic        tmc = 1'b0;

   logic        en0, en1, dlaSync, globalSync, gated;
   logic [31:0] perf;
   logic        en0S, en1S, dlaSyncS, globalSyncS, gatedS;
   logic [3:0]  perfS;

   int checks = 0;
   int failures = 0;
   vec_t vecs[21];

   always #5 clk = ~clk;

   cacc_slcg_ctrl #(.HOLD_W(8), .SYNC_STAGES(2), .PERF_W(32)) dut (
      .nvdla_core_clk                (clk),
      .nvdla_core_rst                (rst),
      .reg2dp_op_en                  (opEn),
      .cfg_hold_cycles               (cfgHold),
      .accu_busy                     (accu),
      .dlv_busy                      (dlv),
      .csc_req_pend                  (csc),
      .dla_clk_ovr_on                (dlaOvr),
      .global_clk_ovr_on             (globalOvr),
      .tmc2slcg_disable_clock_gating (tmc),
      .slcg_en_src_0                 (en0),
      .slcg_en_src_1                 (en1),
      .dla_clk_ovr_on_sync           (dlaSync),
      .global_clk_ovr_on_sync        (globalSync),
      .slcg_gated                    (gated),
      .dp2reg_gated_cycles           (perf)
   );

   // Narrow perf counter instance so saturation is reachable in a short run.
   cacc_slcg_ctrl #(.HOLD_W(8), .SYNC_STAGES(2), .PERF_W(4)) dutSmall (
      .nvdla_core_clk                (clk),
      .nvdla_core_rst                (rst),
      .reg2dp_op_en                  (opEn),
      .cfg_hold_cycles               (cfgHold),
      .accu_busy                     (accu),
      .dlv_busy                      (dlv),
      .csc_req_pend                  (csc),
      .dla_clk_ovr_on                (dlaOvr),
      .global_clk_ovr_on             (globalOvr),
      .tmc2slcg_disable_clock_gating (tmc),
      .slcg_en_src_0                 (en0S),
      .slcg_en_src_1                 (en1S),
      .dla_clk_ovr_on_sync           (dlaSyncS),
      .global_clk_ovr_on_sync        (globalSyncS),
      .slcg_gated                    (gatedS),
      .dp2reg_gated_cycles           (perfS)
   );

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
      checks++;
      if (actual !== expected) begin
         failures++;
         $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, actual, expected);
      end
   endtask

   // Compares {en0, en1, gated} of both instances against one expectation.
   task automatic checkEn(input string name, input logic [2:0] expected);
      checkOutput(name, {29'd0, en0, en1, gated}, {29'd0, expected});
      checkOutput({name, "_small"}, {29'd0, en0S, en1S, gatedS}, {29'd0, expected});
   endtask

   task automatic checkSync(input string name, input logic expDla, input logic expGlobal);
      checkOutput(name, {30'd0, dlaSync, globalSync}, {30'd0, expDla, expGlobal});
      checkOutput({name, "_small"}, {30'd0, dlaSyncS, globalSyncS}, {30'd0, expDla, expGlobal});
   endtask

   task automatic applyStimulus(input vec_t v);
      accu    = v.accu;
      dlv     = v.dlv;
      csc     = v.csc;
      opEn    = v.opEn;
      tmc     = v.tmc;
      cfgHold = v.cfg;
   endtask

   task automatic clearInputs();
      accu = 0; dlv = 0; csc = 0; opEn = 0; tmc = 0; dlaOvr = 0; globalOvr = 0;
   endtask

   initial begin
      #2_000_000;
      $display("[TB] FAIL watchdog: simulation did not finish, got timeout expected completion");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      //              accu dlv  csc  opEn tmc  cfg    {en0,en1,gated}
      vecs[0]  = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'd2, 3'b110};
      vecs[1]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'd2, 3'b010};
      vecs[2]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'd2, 3'b010};
      vecs[3]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'd2, 3'b001};
      vecs[4]  = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 8'd2, 3'b101};
      vecs[5]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 8'd2, 3'b111};
      vecs[6]  = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'd2, 3'b110};
      vecs[7]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0, 3'b001};
      vecs[8]  = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 8'd0, 3'b110};
      vecs[9]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'd1, 3'b010};
      vecs[10] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'd5, 3'b001};
      vecs[11] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'd3, 3'b110};
      vecs[12] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'd3, 3'b010};
      vecs[13] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'd3, 3'b010};
      vecs[14] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'd3, 3'b110};
      vecs[15] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'd1, 3'b010};
      vecs[16] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'd1, 3'b110};
      vecs[17] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'd1, 3'b010};
      vecs[18] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'd1, 3'b001};
      vecs[19] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 8'd1, 3'b111};
      vecs[20] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'd1, 3'b110};

      // Reset state
      clearInputs();
      cfgHold = 8'd0;
      rst = 1;
      step();
      step();
      checkEn("reset_en", 3'b110);
      checkSync("reset_sync", 1'b0, 1'b0);
      checkOutput("reset_perf", perf, 32'd0);
      checkOutput("reset_perf_small", {28'd0, perfS}, 32'd0);

      // Hold-off after reset release: 255 edges still enabled, gated on edge 256
      rst = 0;
      for (int i = 1; i <= 255; i++) step();
      checkEn("post_reset_edge255", 3'b010);
      checkOutput("post_reset_perf_before_gate", perf, 32'd0);
      step();
      checkEn("post_reset_edge256", 3'b001);

      // Gated for 20 cycles, then counter clears on op_en rise
      for (int i = 0; i < 20; i++) step();
      checkOutput("perf_after_20", perf, 32'd20);
      checkOutput("perf_small_saturated", {28'd0, perfS}, 32'd15);
      opEn = 1;
      step();
      checkOutput("perf_clear_on_rise", perf, 32'd0);
      checkOutput("perf_small_clear_on_rise", {28'd0, perfS}, 32'd0);
      checkEn("op_en_gated", 3'b101);
      step();
      checkOutput("perf_count_after_clear", perf, 32'd1);
      opEn = 0;
      step();
      checkEn("op_en_drop", 3'b001);

      // DLA override while gated: sync after 2 edges, enables after 3
      dlaOvr = 1;
      step();
      checkSync("dla_ovr_edge1", 1'b0, 1'b0);
      checkEn("dla_ovr_edge1_en", 3'b001);
      step();
      checkSync("dla_ovr_edge2", 1'b1, 1'b0);
      checkEn("dla_ovr_edge2_en", 3'b001);
      step();
      checkEn("dla_ovr_edge3_en", 3'b111);
      dlaOvr = 0;
      step();
      step();
      checkSync("dla_ovr_release_sync", 1'b0, 1'b0);
      checkEn("dla_ovr_release_edge2", 3'b111);
      step();
      checkEn("dla_ovr_release_edge3", 3'b001);

      // Global override path
      globalOvr = 1;
      step();
      step();
      checkSync("global_ovr_edge2", 1'b0, 1'b1);
      checkEn("global_ovr_edge2_en", 3'b001);
      step();
      checkEn("global_ovr_edge3_en", 3'b111);
      globalOvr = 0;
      for (int i = 0; i < 3; i++) step();
      checkEn("global_ovr_release", 3'b001);

      // Vector table from a fresh reset (HOLD, counter all-ones)
      rst = 1;
      step();
      rst = 0;
      for (int i = 0; i < 21; i++) begin
         applyStimulus(vecs[i]);
         step();
         checkEn($sformatf("vec%0d", i), vecs[i].expOut);
      end

      // Hold of 4: enable drops exactly 5 edges after busy falls
      clearInputs();
      cfgHold = 8'd4;
      accu = 1;
      for (int i = 0; i < 10; i++) step();
      checkEn("pulse_active", 3'b110);
      accu = 0;
      for (int i = 1; i <= 4; i++) begin
         step();
         checkEn($sformatf("hold4_edge%0d", i), 3'b010);
      end
      step();
      checkEn("hold4_edge5", 3'b001);

      // Re-pulse when hold count is 1: no gap in enable
      accu = 1;
      for (int i = 0; i < 10; i++) step();
      accu = 0;
      for (int i = 0; i < 3; i++) step();
      checkEn("repulse_cnt1", 3'b010);
      accu = 1;
      step();
      checkEn("repulse_active", 3'b110);
      step();
      checkEn("repulse_active2", 3'b110);

      // Reset in HOLD with count 3 reloads all-ones
      accu = 0;
      step();
      rst = 1;
      step();
      checkEn("mid_reset_en", 3'b110);
      checkOutput("mid_reset_perf", perf, 32'd0);
      rst = 0;
      for (int i = 1; i <= 255; i++) step();
      checkEn("mid_reset_edge255", 3'b010);
      step();
      checkEn("mid_reset_edge256", 3'b001);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
